multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences a shared ALU, a single instruction/data memory port and the register file through the fetch, decode, execute, memory and write-back steps. It replaces the single-cycle decoder/ALU_Ctrl pairing: it consumes opcode/funct from the instruction register and drives every datapath select and write strobe. It also counts retired instructions.

## Interface
- No parameters; all encodings come from `mcc_pkg`.
- `clk_i` in 1: system clock, rising-edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `opcode_i` in 6: IR[31:26].
- `funct_i` in 6: IR[5:0].
- `zero_i` in 1: ALU zero flag, valid in BRANCH.
- `mem_ready_i` in 1: memory access completes this cycle (used only with `MCC_MEM_WAIT_EN`).
- `pc_write_o` out 1: PC load enable.
- `iord_o` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read_o`, `mem_write_o` out 1 each: memory strobes.
- `ir_write_o` out 1: instruction register load.
- `reg_write_o` out 1: register file write.
- `reg_dst_o` out 2: 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg_o` out 2: 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a_o` out 1: 0 = PC, 1 = A.
- `alu_src_b_o` out 2: 00 = B, 01 = 4, 10 = sext, 11 = sext<<2.
- `alu_op_o` out 3: 000 = add, 001 = sub, 010 = use funct, 011 = slt.
- `pc_source_o` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr).
- `illegal_o` out 1: one-cycle pulse on an unsupported opcode.
- `retired_o` out 32: retired-instruction count.

## Operation
- Supported: R-type (op 0), `jr` (op 0, funct 001000), `lw` 35, `sw` 43, `beq` 4, `bne` 5, `addi` 8, `slti` 10, `j` 2, `jal` 3.
- States and per-state actions:
  - IDLE: reset state; all strobes 0.
  - FETCH: mem_read, ir_write, pc_write; src_a = PC, src_b = 4, add, pc_source = 00.
  - DECODE: src_a = PC, src_b = sext<<2, add; the branch target goes to ALUOut.
  - MEM_ADDR: src_a = A, src_b = sext, add.
  - MEM_RD: iord = 1, mem_read.
  - MEM_WB: reg_write, reg_dst = rt, mem_to_reg = MDR.
  - MEM_WR: iord = 1, mem_write.
  - EXEC_R: src_a = A, src_b = B, alu_op = funct.
  - R_WB: reg_write, reg_dst = rd, mem_to_reg = ALUOut.
  - EXEC_I: src_a = A, src_b = sext; add for addi, slt for slti.
  - I_WB: reg_write, reg_dst = rt, mem_to_reg = ALUOut.
  - BRANCH: src_a = A, src_b = B, sub, pc_source = 01.
  - JUMP: pc_write, pc_source = 10.
  - JAL: JUMP actions plus reg_write, reg_dst = $31, mem_to_reg = PC. PC already holds PC+4 from FETCH.
  - JR: pc_write, pc_source = 11.
- Transitions:
  - IDLE→FETCH, FETCH→DECODE.
  - DECODE dispatches on opcode/funct:
    - lw/sw → MEM_ADDR, then lw → MEM_RD→MEM_WB, sw → MEM_WR.
    - R-type → EXEC_R→R_WB, except funct 001000 → JR.
    - addi/slti → EXEC_I→I_WB.
    - beq/bne → BRANCH.
    - j → JUMP, jal → JAL.
  - All terminal states → FETCH.
- Illegal opcode in DECODE: pulse `illegal_o`, go to FETCH. The instruction is not retired and no write strobes are asserted.
- `retired_o` increments by 1 on every transition from a terminal state to FETCH. It wraps at 2^32−1 → 0.
- BRANCH: `pc_write_o` = (`zero_i` XNOR is_beq), i.e. beq takes when zero = 1 and bne takes when zero = 0.

## Timing
- State, `retired_o` and all outputs except `pc_write_o`, `ir_write_o` and `illegal_o` are registered. They are decoded from the next state, so they are valid for the whole cycle spent in a state.
- `pc_write_o` and `ir_write_o` are combinational from registered strobes qualified by `zero_i` (BRANCH) and `mem_ready_i` (FETCH).
- Reset value of every output is 0, and `retired_o` = 0. The first FETCH occurs in the second cycle after reset deasserts.
- Latency with no waits:
  - j/jal/jr/beq/bne: 3 cycles.
  - R-type/addi/slti/sw: 4 cycles.
  - lw: 5 cycles.
- Reset asserted mid-instruction: go immediately to IDLE, outputs 0, counter cleared. A partial access is abandoned.

## Configuration
- `MCC_MEM_WAIT_EN` defined:
  - FETCH, MEM_RD and MEM_WR hold their state and outputs until `mem_ready_i` = 1.
  - `ir_write_o`/`pc_write_o` assert in FETCH only in the `mem_ready_i` cycle.
- Undefined: `mem_ready_i` is ignored and each memory state lasts exactly one cycle.

## Structure
- `mcc_pkg` holds:
  - the state enum (4-bit);
  - opcode/funct constants;
  - ALUOp, ALUSrcB, PCSource, RegDst and MemtoReg encodings.
- The datapath imports the same encodings.
- One sub-module, `mcc_retire_cnt`: 32-bit counter with async active-low clear and an increment enable.
- The FSM and output decode stay in `multicycle_ctrl`.

## Test plan
- Reset released, `lw` (op 35) held → states IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. Writeback shows reg_dst = 00 and mem_to_reg = 01; `retired_o` = 1 after 6 cycles.
- `beq` with `zero_i` = 1, then `bne` with `zero_i` = 1 → `pc_write_o` = 1 in BRANCH for beq and 0 for bne; each takes 3 cycles.
- `jal` → JAL cycle shows reg_write = 1, reg_dst = 10, mem_to_reg = 10, pc_source = 10, pc_write = 1. `jr` (funct 8) → pc_source = 11 and reg_write = 0.
- Opcode 6'h3F → `illegal_o` pulses one cycle, next state FETCH, `retired_o` unchanged.
- With `MCC_MEM_WAIT_EN`, `mem_ready_i` low for 3 cycles in FETCH → stays in FETCH with `ir_write_o` = 0 for 3 cycles, then advances on the ready cycle.
- Reset pulsed during MEM_WR → `mem_write_o` drops immediately, `retired_o` = 0, FETCH resumes 2 cycles after release.

Source files
------------

// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and its datapath.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010, ALU_SLT = 3'b011
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_SEXT = 2'b10, SRCB_SEXT_SH2 = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_REG = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_RA = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10
  } mem_to_reg_t;

  typedef struct packed {
    logic        ir_wr;
    logic        pc_wr;
    logic        fetch;
    logic        branch;
    logic        beq;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    reg_dst_t    reg_dst;
    mem_to_reg_t mem_to_reg;
    logic        alu_src_a;
    src_b_t      alu_src_b;
    alu_op_t     alu_op;
    pc_src_t     pc_source;
  } ctrl_t;

  function automatic logic is_terminal(input state_t s);
    return s inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the datapath.
interface multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [1:0]  pc_source;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal, retired
  );
endinterface

// File: rtl/mcc_retire_cnt.sv
// 32-bit retired-instruction counter with async active-low clear; wraps naturally.
module mcc_retire_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (inc) count <= count + 32'd1;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM. Optional macro MCC_MEM_WAIT_EN stretches
// FETCH/MEM_RD/MEM_WR until mem_ready is high.
module multicycle_ctrl
  import mcc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_t state, state_next;
  ctrl_t  ctrl_q;
  logic   mem_done;
  logic   illegal;

`ifdef MCC_MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = bus.mem_ready;
  assign mem_done         = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    illegal    = 1'b0;
    case (state)
      S_IDLE:     state_next = S_FETCH;
      S_FETCH:    state_next = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:     state_next = S_MEM_ADDR;
          OP_RTYPE:         state_next = (bus.funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_SLTI: state_next = S_EXEC_I;
          OP_BEQ, OP_BNE:   state_next = S_BRANCH;
          OP_J:             state_next = S_JUMP;
          OP_JAL:           state_next = S_JAL;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_next = mem_done ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_next = mem_done ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_next = S_R_WB;
      S_EXEC_I:   state_next = S_I_WB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they hold for the whole state cycle.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_wr = 1'b1; c.pc_wr = 1'b1; c.fetch = 1'b1; c.mem_read = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE:   c.alu_src_b = SRCB_SEXT_SH2;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_SEXT; end
      S_MEM_RD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = M2R_MDR; end
      S_MEM_WR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT; end
      S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = RDST_RD; end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_SEXT;
        c.alu_op = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB:     c.reg_write = 1'b1;
      S_BRANCH: begin
        c.branch = 1'b1; c.beq = (op == OP_BEQ);
        c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_source = PCSRC_ALUOUT;
      end
      S_JUMP:     begin c.pc_wr = 1'b1; c.pc_source = PCSRC_JUMP; end
      S_JAL: begin
        c.pc_wr = 1'b1; c.pc_source = PCSRC_JUMP;
        c.reg_write = 1'b1; c.reg_dst = RDST_RA; c.mem_to_reg = M2R_PC;
      end
      S_JR:       begin c.pc_wr = 1'b1; c.pc_source = PCSRC_REG; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= decode(state_next, bus.opcode);
  end

  mcc_retire_cnt u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (is_terminal(state) && (state_next == S_FETCH)),
    .count (bus.retired)
  );

  assign bus.pc_write   = (ctrl_q.pc_wr && (!ctrl_q.fetch || mem_done))
                        || (ctrl_q.branch && !(bus.zero ^ ctrl_q.beq));
  assign bus.ir_write   = ctrl_q.ir_wr && mem_done;
  assign bus.illegal    = illegal;
  assign bus.iord       = ctrl_q.iord;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.pc_source  = ctrl_q.pc_source;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; covers the MCC_MEM_WAIT_EN build when defined.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [18:0] pat(
    input logic pcw, iord, mrd, mwr, irw, rw, input logic [1:0] rdst, m2r,
    input logic sa, input logic [1:0] sb, input logic [2:0] aop,
    input logic [1:0] ps, input logic ill);
    return {pcw, iord, mrd, mwr, irw, rw, rdst, m2r, sa, sb, aop, ps, ill};
  endfunction

  task automatic expect_st(input string tag, input logic [18:0] exp);
    @(negedge clk);
    check_eq(tag, 32'(obs), 32'(exp));
  endtask

  logic [18:0] P_FETCH, P_FETCH_WAIT, P_DECODE, P_DECODE_ILL, P_MADDR, P_MRD, P_MWB,
               P_MWR, P_EXR, P_RWB, P_EXI_ADD, P_EXI_SLT, P_IWB, P_BR_T, P_BR_N,
               P_JUMP, P_JAL, P_JR;

  initial begin
    P_FETCH      = pat(1,0,1,0,1,0,2'b00,2'b00,0,2'b01,3'b000,2'b00,0);
    P_FETCH_WAIT = pat(0,0,1,0,0,0,2'b00,2'b00,0,2'b01,3'b000,2'b00,0);
    P_DECODE     = pat(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b000,2'b00,0);
    P_DECODE_ILL = pat(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b000,2'b00,1);
    P_MADDR      = pat(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b000,2'b00,0);
    P_MRD        = pat(0,1,1,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0);
    P_MWB        = pat(0,0,0,0,0,1,2'b00,2'b01,0,2'b00,3'b000,2'b00,0);
    P_MWR        = pat(0,1,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0);
    P_EXR        = pat(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b010,2'b00,0);
    P_RWB        = pat(0,0,0,0,0,1,2'b01,2'b00,0,2'b00,3'b000,2'b00,0);
    P_EXI_ADD    = pat(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b000,2'b00,0);
    P_EXI_SLT    = pat(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b011,2'b00,0);
    P_IWB        = pat(0,0,0,0,0,1,2'b00,2'b00,0,2'b00,3'b000,2'b00,0);
    P_BR_T       = pat(1,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b001,2'b01,0);
    P_BR_N       = pat(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b001,2'b01,0);
    P_JUMP       = pat(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b10,0);
    P_JAL        = pat(1,0,0,0,0,1,2'b10,2'b10,0,2'b00,3'b000,2'b10,0);
    P_JR         = pat(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b11,0);

    rst_n      = 1'b0;
    bus.opcode = 6'd35;
    bus.funct  = 6'd0;
    bus.zero   = 1'b0;
`ifdef MCC_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`else
    bus.mem_ready = 1'b0;   // must be ignored in this build
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", 32'(obs), 32'd0);
    check_eq("rst_retired", bus.retired, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // lw
    expect_st("lw_idle", 19'd0);
    expect_st("lw_fetch", P_FETCH);
    expect_st("lw_decode", P_DECODE);
    expect_st("lw_maddr", P_MADDR);
    expect_st("lw_mrd", P_MRD);
    expect_st("lw_mwb", P_MWB);
    expect_st("lw_fetch2", P_FETCH);
    check_eq("lw_retired", bus.retired, 32'd1);

    // beq taken, bne not taken (zero=1), bne taken (zero=0)
    bus.opcode = 6'd4; bus.zero = 1'b1;
    expect_st("beq_decode", P_DECODE);
    expect_st("beq_branch", P_BR_T);
    expect_st("beq_fetch", P_FETCH);
    check_eq("beq_retired", bus.retired, 32'd2);
    bus.opcode = 6'd5; bus.zero = 1'b1;
    expect_st("bne_decode", P_DECODE);
    expect_st("bne_z1_branch", P_BR_N);
    expect_st("bne_fetch", P_FETCH);
    check_eq("bne_retired", bus.retired, 32'd3);
    bus.zero = 1'b0;
    expect_st("bne_z0_decode", P_DECODE);
    expect_st("bne_z0_branch", P_BR_T);
    expect_st("bne_z0_fetch", P_FETCH);

    // jal, jr
    bus.opcode = 6'd3;
    expect_st("jal_decode", P_DECODE);
    expect_st("jal_jal", P_JAL);
    expect_st("jal_fetch", P_FETCH);
    bus.opcode = 6'd0; bus.funct = 6'b001000;
    expect_st("jr_decode", P_DECODE);
    expect_st("jr_jr", P_JR);
    expect_st("jr_fetch", P_FETCH);
    check_eq("jr_retired", bus.retired, 32'd6);

    // R-type add, addi, slti, j
    bus.funct = 6'h20;
    expect_st("r_decode", P_DECODE);
    expect_st("r_exec", P_EXR);
    expect_st("r_wb", P_RWB);
    expect_st("r_fetch", P_FETCH);
    bus.opcode = 6'd8;
    expect_st("addi_decode", P_DECODE);
    expect_st("addi_exec", P_EXI_ADD);
    expect_st("addi_wb", P_IWB);
    expect_st("addi_fetch", P_FETCH);
    bus.opcode = 6'd10;
    expect_st("slti_decode", P_DECODE);
    expect_st("slti_exec", P_EXI_SLT);
    expect_st("slti_wb", P_IWB);
    expect_st("slti_fetch", P_FETCH);
    bus.opcode = 6'd2;
    expect_st("j_decode", P_DECODE);
    expect_st("j_jump", P_JUMP);
    expect_st("j_fetch", P_FETCH);
    check_eq("j_retired", bus.retired, 32'd10);

    // illegal opcode
    bus.opcode = 6'h3F;
    expect_st("ill_decode", P_DECODE_ILL);
    expect_st("ill_fetch", P_FETCH);
    check_eq("ill_retired", bus.retired, 32'd10);

    // sw interrupted by reset in MEM_WR
    bus.opcode = 6'd43;
    expect_st("sw_decode", P_DECODE);
    expect_st("sw_maddr", P_MADDR);
    expect_st("sw_mwr", P_MWR);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_mem_write", 32'(bus.mem_write), 32'd0);
    check_eq("rstmid_outputs", 32'(obs), 32'd0);
    check_eq("rstmid_retired", bus.retired, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_st("rel_idle", 19'd0);
`ifdef MCC_MEM_WAIT_EN
    bus.mem_ready = 1'b0;
    expect_st("wait_fetch0", P_FETCH_WAIT);
    expect_st("wait_fetch1", P_FETCH_WAIT);
    expect_st("wait_fetch2", P_FETCH_WAIT);
    bus.mem_ready = 1'b1;
    expect_st("wait_fetch_rdy", P_FETCH);
`else
    expect_st("rel_fetch", P_FETCH);
`endif
    expect_st("rel_decode", P_DECODE);
    check_eq("rel_retired", bus.retired, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
